// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state encoding, block type and byte-level round helpers
package aes_pkg;
  localparam int Nb = 4;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef logic [0:32*Nb-1] block_t;
  function automatic logic [0:7] xtime(input logic [0:7] b);
    return {b[1:7], 1'b0} ^ (b[0] ? 8'h1b : 8'h00);
  endfunction
  function automatic block_t shift_rows(input block_t s);
    block_t o;
    for (int c = 0; c < Nb; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%Nb)+r) +: 8];
    return o;
  endfunction
  function automatic block_t mix_columns(input block_t s);
    block_t o;
    logic [0:7] a0, a1, a2, a3;
    for (int c = 0; c < Nb; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction
endpackage

// File: rtl/aes_cipher_iter_sbox.sv
// aes_sbox: combinational AES S-box, GF(2^8) inverse (x^254) followed by the affine map
module aes_sbox (
  input  logic [0:7] i_a,
  output logic [0:7] o_s
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] t, p;
    t = a;
    p = 8'h01;
    for (int k = 1; k < 8; k++) begin
      t = gmul(t, t);
      p = gmul(p, t);
    end
    return p;
  endfunction
  logic [7:0] w_inv;
  assign w_inv = ginv(i_a);
  assign o_s = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
             ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES encryptor, one round per clock, valid/ready on both sides.
// Define AES_CIPHER_SCHED_LATCH_EN to capture the key schedule on the accepting edge.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:128*(Nr+1)-1] schedule,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:127]          plaintext,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:127]          ciphertext
);
  localparam int RW = $clog2(Nr + 1);
  if (Nr != Nk + 6) begin : g_bad_cfg
    $error("aes_cipher_iter: Nr must equal Nk + 6");
  end
  state_t        r_fsm;
  block_t        r_state, r_ct;
  logic [RW-1:0] r_round;
  logic          r_in_ready, r_out_valid;
  block_t        w_sb, w_sr, w_rk, w_next;
`ifdef AES_CIPHER_SCHED_LATCH_EN
  logic [128:128*(Nr+1)-1] r_sched;
  always_ff @(posedge clk)
    if (!rst && r_fsm == IDLE && in_valid) r_sched <= schedule[128:128*(Nr+1)-1];
  assign w_rk = r_sched[{r_round, 7'b0} +: 128];
`else
  assign w_rk = schedule[{r_round, 7'b0} +: 128];
`endif
  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sbox (.i_a(r_state[8*i +: 8]), .o_s(w_sb[8*i +: 8]));
  end
  assign w_sr = shift_rows(w_sb);
  assign w_next = (r_round == RW'(Nr) ? w_sr : mix_columns(w_sr)) ^ w_rk;
  assign in_ready = r_in_ready;
  assign out_valid = r_out_valid;
  assign ciphertext = r_ct;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= IDLE;
      r_in_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_ct <= '0;
      r_round <= '0;
      r_state <= '0;
    end else begin
      case (r_fsm)
        IDLE: if (in_valid) begin
          r_state <= plaintext ^ schedule[0:127];
          r_round <= RW'(1);
          r_in_ready <= 1'b0;
          r_fsm <= BUSY;
        end
        BUSY: begin
          r_state <= w_next;
          if (r_round == RW'(Nr)) begin
            r_ct <= w_next;
            r_out_valid <= 1'b1;
            r_fsm <= DONE;
          end else r_round <= r_round + 1'b1;
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready <= 1'b1;
          r_fsm <= IDLE;
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb_aes_cipher_iter: scoreboard bench for aes_cipher_iter (Nk=4/Nr=10 and Nk=8/Nr=14 instances)
`timescale 1ns/1ps
module tb_aes_cipher_iter;
  typedef struct { logic [0:127] ct; int acc; } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] sbox [256];

  logic [0:1407] sched4;
  logic          in_valid4 = 1'b0, out_ready4 = 1'b1, in_ready4, out_valid4;
  logic [0:127]  pt4, ct4;
  logic [0:1919] sched8;
  logic          in_valid8 = 1'b0, out_ready8 = 1'b1, in_ready8, out_valid8;
  logic [0:127]  pt8, ct8;
  exp_t sb4[$], sb8[$];
  logic pv4 = 1'b0, pv8 = 1'b0;

  aes_cipher_iter #(.Nk(4), .Nr(10)) dut4 (
    .clk(clk), .rst(rst), .schedule(sched4), .in_valid(in_valid4), .in_ready(in_ready4),
    .plaintext(pt4), .out_valid(out_valid4), .out_ready(out_ready4), .ciphertext(ct4));
  aes_cipher_iter #(.Nk(8), .Nr(14)) dut8 (
    .clk(clk), .rst(rst), .schedule(sched8), .in_valid(in_valid8), .in_ready(in_ready8),
    .plaintext(pt8), .out_valid(out_valid8), .out_ready(out_ready8), .ciphertext(ct8));

  function automatic void chk(string nm, logic [0:127] got, logic [0:127] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, got, req, $time);
    end
  endfunction
  function automatic void chk1(string nm, logic got, logic req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %b required %b (t=%0t)", nm, got, req, $time);
    end
  endfunction
  function automatic void chki(string nm, int got, int req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, got, req, $time);
    end
  endfunction

  // Reference model: textbook AES on a 4x4 byte matrix
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction
  function automatic logic [0:1919] expand(input logic [0:255] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [0:1919] s;
    rc = 8'h01;
    s = '0;
    for (int i = 0; i < 4*(nk+7); i++) begin
      if (i < nk) t = key[32*i +: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gm(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        t = t ^ w[i-nk];
      end
      w[i] = t;
      s[32*i +: 32] = t;
    end
    return s;
  endfunction
  function automatic logic [0:127] enc(input logic [0:127] pt, input logic [0:1919] sch, input int nr);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [0:127] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = pt[32*c+8*r +: 8] ^ sch[32*c+8*r +: 8];
    for (int k = 1; k <= nr; k++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r][c] = sbox[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = (k < nr ? gm(8'h02, t[r][c]) ^ gm(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c]
                            : t[r][c]) ^ sch[128*k+32*c+8*r +: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[32*c+8*r +: 8] = s[r][c];
    return o;
  endfunction
  // S-box from the generator-3 walk: p steps by *3, q tracks p's inverse
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (rst) pv4 = 1'b0;
    else begin
      if (out_valid4) begin
        if (sb4.size() == 0) chk1("dut4 out_valid with nothing pending", out_valid4, 1'b0);
        else begin
          if (!pv4) chki("dut4 latency", cyc - sb4[0].acc, 10);
          chk("dut4 ciphertext", ct4, sb4[0].ct);
          chk1("dut4 in_ready while out_valid", in_ready4, 1'b0);
          if (out_ready4) void'(sb4.pop_front());
        end
      end
      pv4 = out_valid4;
    end
  end
  always @(negedge clk) begin
    if (rst) pv8 = 1'b0;
    else begin
      if (out_valid8) begin
        if (sb8.size() == 0) chk1("dut8 out_valid with nothing pending", out_valid8, 1'b0);
        else begin
          if (!pv8) chki("dut8 latency", cyc - sb8[0].acc, 14);
          chk("dut8 ciphertext", ct8, sb8[0].ct);
          chk1("dut8 in_ready while out_valid", in_ready8, 1'b0);
          if (out_ready8) void'(sb8.pop_front());
        end
      end
      pv8 = out_valid8;
    end
  end

  task automatic send4(input logic [0:127] pt, input logic [0:127] ct);
    int n = 0;
    pt4 = pt;
    in_valid4 = 1'b1;
    @(negedge clk);
    while (!in_ready4 && n < 200) begin n++; @(negedge clk); end
    if (in_ready4) sb4.push_back('{ct, cyc + 1});
    else chk1("dut4 accept timeout", in_ready4, 1'b1);
    @(posedge clk); #1 in_valid4 = 1'b0;
  endtask
  task automatic send8(input logic [0:127] pt, input logic [0:127] ct);
    int n = 0;
    pt8 = pt;
    in_valid8 = 1'b1;
    @(negedge clk);
    while (!in_ready8 && n < 200) begin n++; @(negedge clk); end
    if (in_ready8) sb8.push_back('{ct, cyc + 1});
    else chk1("dut8 accept timeout", in_ready8, 1'b1);
    @(posedge clk); #1 in_valid8 = 1'b0;
  endtask
  task automatic drain4();
    int n = 0;
    while ((sb4.size() != 0 || !in_ready4) && n < 400) begin n++; @(negedge clk); end
    chk1("dut4 drain timeout", n < 400, 1'b1);
    @(posedge clk); #1;
  endtask
  task automatic drain8();
    int n = 0;
    while ((sb8.size() != 0 || !in_ready8) && n < 400) begin n++; @(negedge clk); end
    chk1("dut8 drain timeout", n < 400, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:1919] s;
    logic [0:127] a, b;
    int n;
    build_sbox();
    pt4 = '0; pt8 = '0; sched4 = '0; sched8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk1("dut4 reset in_ready", in_ready4, 1'b1);
    chk1("dut4 reset out_valid", out_valid4, 1'b0);
    chk("dut4 reset ciphertext", ct4, '0);
    chk1("dut8 reset in_ready", in_ready8, 1'b1);
    chk1("dut8 reset out_valid", out_valid8, 1'b0);
    chk("dut8 reset ciphertext", ct8, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    s = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    sched4 = s[0:1407];
    send4(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    drain4();
    s = expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    sched4 = s[0:1407];
    send4(128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);
    drain4();
    sched8 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    send8(128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089);
    drain8();

    // Output back-pressure with a second plaintext waiting
    out_ready4 = 1'b0;
    a = rnd128();
    b = rnd128();
    send4(a, enc(a, s, 10));
    n = 0;
    while (!out_valid4 && n < 100) begin n++; @(negedge clk); end
    chk1("dut4 out_valid before stall", out_valid4, 1'b1);
    @(posedge clk); #1;
    pt4 = b;
    in_valid4 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk1("dut4 stall out_valid held", out_valid4, 1'b1);
    end
    @(posedge clk); #1 out_ready4 = 1'b1;
    send4(b, enc(b, s, 10));
    drain4();

    // Reset in the middle of an operation
    a = rnd128();
    send4(a, enc(a, s, 10));
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    sb4.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk1("dut4 abort in_ready", in_ready4, 1'b1);
    chk1("dut4 abort out_valid", out_valid4, 1'b0);
    chk("dut4 abort ciphertext", ct4, '0);
    @(posedge clk); #1;
    a = rnd128();
    send4(a, enc(a, s, 10));
    drain4();

    for (int i = 0; i < 4; i++) begin
      s = expand({rnd128(), 128'h0}, 4);
      sched4 = s[0:1407];
      for (int j = 0; j < 3; j++) begin
        a = rnd128();
        send4(a, enc(a, s, 10));
      end
      drain4();
    end
    for (int i = 0; i < 3; i++) begin
      s = expand({rnd128(), rnd128()}, 8);
      sched8 = s;
      for (int j = 0; j < 2; j++) begin
        a = rnd128();
        send8(a, enc(a, s, 14));
      end
      drain8();
    end

`ifdef AES_CIPHER_SCHED_LATCH_EN
    s = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    sched4 = s[0:1407];
    send4(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    sched4 = '0;
    drain4();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_cipher_iter.md
AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

Interface
REQ-001 SHALL have parameter Nk, default 4, key length in 32-bit words (4, 6 or 8).
REQ-002 SHALL have parameter Nr, default 10, round count (10, 12 or 14, matching Nk).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port schedule  input  128*(Nr+1)  expanded key; bit 0 is the MSB; round key r is bits [128*r +: 128].
REQ-006 SHALL have port in_valid  input  1  plaintext offered.
REQ-007 SHALL have port in_ready  output  1  block can accept a plaintext.
REQ-008 SHALL have port plaintext  input  128  FIPS-197 byte order; byte 0 is in bits [0:7].
REQ-009 SHALL have port out_valid  output  1  ciphertext valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts ciphertext.
REQ-011 SHALL have port ciphertext  output  128  result, in the same byte order as plaintext.

Function
REQ-012 SHALL implement a state machine with states IDLE, BUSY and DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE; in_ready is a registered state decode with no combinational path from any input.
REQ-014 SHALL, on in_valid && in_ready, load state <= plaintext ^ round key 0, set round counter to 1 and enter BUSY.
REQ-015 SHALL, in BUSY, on each edge apply SubBytes, ShiftRows, MixColumns and AddRoundKey(round key r), then increment r.
REQ-016 SHALL, when r == Nr, omit MixColumns, register the result to ciphertext, set out_valid and enter DONE.
REQ-017 SHALL assert out_valid exactly Nr edges after the accepting edge.
REQ-018 SHALL hold ciphertext and out_valid stable in DONE until out_ready == 1.
REQ-019 SHALL, on out_valid && out_ready, clear out_valid and return to IDLE; the next plaintext is accepted no earlier than the following edge.
REQ-020 SHALL ignore in_valid while in BUSY or DONE; no plaintext is dropped silently, because in_ready is 0 in those states.
REQ-021 SHALL make the round counter ceil(log2(Nr+1)) bits wide; it never wraps past Nr.
REQ-022 SHALL compute MixColumns xtime as {b[1:7],1'b0} ^ (b[0] ? 8'h1b : 8'h00).
REQ-023 SHALL ignore out_ready in IDLE and BUSY.

Reset
REQ-024 SHALL, on rst, force IDLE, in_ready = 1, out_valid = 0, ciphertext = 0 and round counter = 0.
REQ-025 SHALL, on rst in BUSY or DONE, abandon the operation without producing output; rst has priority over every handshake.

Configuration
REQ-026 SHALL, when macro AES_CIPHER_SCHED_LATCH_EN is defined, capture schedule into an internal register on the accepting edge and use that register for rounds 1..Nr, so schedule may change mid-operation.
REQ-027 SHALL, when AES_CIPHER_SCHED_LATCH_EN is undefined, read schedule directly each round; the producer must then hold schedule stable from acceptance until out_valid && out_ready.

Structure
REQ-028 SHALL take the following from shared package aes_pkg: state encoding typedef, Nb = 4, the 128-bit block typedef, and the xtime and ShiftRows helper functions.
REQ-029 SHALL instantiate 16 copies of combinational sub-module aes_sbox (8-bit in, 8-bit out) for SubBytes.

Verification
REQ-030 SHALL cover: Nk=4; key 000102..0f expanded; plaintext 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid 10 edges after accept.
REQ-031 SHALL cover: Nk=4; key 2b7e151628aed2a6abf7158809cf4f3c; plaintext 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32.
REQ-032 SHALL cover: Nk=8, Nr=14; key 00..1f; plaintext 00112233..ff -> ciphertext 8ea2b7ca516745bfeafc49904b496089, with out_valid 14 edges after accept.
REQ-033 SHALL cover: out_ready held 0 for 5 cycles in DONE -> ciphertext and out_valid stable and in_ready = 0 throughout; the second in_valid is accepted only after the drain.
REQ-034 SHALL cover: rst pulsed at round 5 -> next cycle IDLE, out_valid = 0, in_ready = 1; a following vector gives the correct result.
REQ-035 SHALL cover: with AES_CIPHER_SCHED_LATCH_EN defined, schedule changed to all-zeros one cycle after accept -> result still 69c4e0d86a7b0430d8cdb78070b4c55a.
